// File: rtl/tb_sys_ctrl.sv
// tb_sys_ctrl: run controller for CPU simulation benches.
//
// It holds the CPU in reset for RST_CYCLES cycles after system reset releases.
// It then counts run cycles and retired instructions. The run ends on an
// ebreak halt, which latches the trap code and the pass flag, or on a
// cycle-limit timeout. The block then freezes the CPU and holds its results
// until the next system reset.
//
// Ports:
//   i_sys_clk      system clock, rising edge
//   i_sys_rst_n    synchronous active-low system reset
//   i_inst_commit  CPU retired one instruction this cycle
//   i_ebreak       CPU executed ebreak this cycle
//   i_trap_code    CPU a0 value, valid with i_ebreak
//   o_cpu_rst_n    registered active-low reset to the CPU
//   o_state        0 RST, 1 RUN, 2 DONE
//   o_cycle_cnt    cycles spent in RUN (saturating)
//   o_inst_cnt     instructions committed in RUN (saturating)
//   o_done         run finished (sticky)
//   o_pass         finished by ebreak with trap code == PASS_CODE
//   o_timeout      finished by cycle limit
//   o_trap_code    trap code latched at halt
module tb_sys_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned RST_CYCLES = 10,
    parameter int unsigned MAX_CYCLES = 1000,
    parameter int unsigned PASS_CODE  = 0
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    input  logic                  i_inst_commit,
    input  logic                  i_ebreak,
    input  logic [DATA_WIDTH-1:0] i_trap_code,
    output logic                  o_cpu_rst_n,
    output logic [1:0]            o_state,
    output logic [CNT_WIDTH-1:0]  o_cycle_cnt,
    output logic [CNT_WIDTH-1:0]  o_inst_cnt,
    output logic                  o_done,
    output logic                  o_pass,
    output logic                  o_timeout,
    output logic [DATA_WIDTH-1:0] o_trap_code
);

    typedef enum logic [1:0] {
        StRst  = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [31:0] RstLast = 32'(RST_CYCLES - 1);
    // Compared at 64 bits so a limit wider than the counter can never falsely match.
    localparam logic [63:0] MaxLast = 64'(MAX_CYCLES) - 64'd1;
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    state_e                state_q, state_d;
    logic [31:0]           rst_cnt_q, rst_cnt_d;
    logic [CNT_WIDTH-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_WIDTH-1:0]  inst_cnt_q, inst_cnt_d;
    logic                  cpu_rst_n_q, cpu_rst_n_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  timeout_q, timeout_d;
    logic [DATA_WIDTH-1:0] trap_code_q, trap_code_d;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        inst_cnt_d  = inst_cnt_q;
        cpu_rst_n_d = cpu_rst_n_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        trap_code_d = trap_code_q;

        unique case (state_q)
            StRst: begin
                if (rst_cnt_q == RstLast) begin
                    state_d     = StRun;
                    cpu_rst_n_d = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + 32'd1;
                end
            end
            StRun: begin
                if (cycle_cnt_q != CntMax) begin
                    cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
                end
                if (i_inst_commit && (inst_cnt_q != CntMax)) begin
                    inst_cnt_d = inst_cnt_q + CNT_WIDTH'(1);
                end
                // ebreak takes priority over a timeout in the same cycle.
                if (i_ebreak) begin
                    state_d     = StDone;
                    cpu_rst_n_d = 1'b0;
                    done_d      = 1'b1;
                    trap_code_d = i_trap_code;
                    pass_d      = (i_trap_code == DATA_WIDTH'(PASS_CODE));
                end else if ((MAX_CYCLES != 0) && (64'(cycle_cnt_q) == MaxLast)) begin
                    state_d     = StDone;
                    cpu_rst_n_d = 1'b0;
                    done_d      = 1'b1;
                    timeout_d   = 1'b1;
                end
            end
            StDone: begin
                cpu_rst_n_d = 1'b0;
            end
            default: begin
                state_d     = StRst;
                cpu_rst_n_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n) begin
            state_q     <= StRst;
            rst_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            trap_code_q <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            trap_code_q <= trap_code_d;
        end
    end

    assign o_cpu_rst_n = cpu_rst_n_q;
    assign o_state     = state_q;
    assign o_cycle_cnt = cycle_cnt_q;
    assign o_inst_cnt  = inst_cnt_q;
    assign o_done      = done_q;
    assign o_pass      = pass_q;
    assign o_timeout   = timeout_q;
    assign o_trap_code = trap_code_q;

endmodule

// File: tb/tb_tb_sys_ctrl.sv
// Bench for tb_sys_ctrl.
// dut_a: RST_CYCLES=4, MAX_CYCLES=50, 32-bit counters.
// dut_b: RST_CYCLES=4, MAX_CYCLES=0, 4-bit counters, for the saturation check.
// Both instances share the clock, the reset and the inputs.
module tb_tb_sys_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        commit = 1'b0;
    logic        ebreak = 1'b0;
    logic [31:0] code = '0;

    logic        a_cpu_rst_n, a_done, a_pass, a_timeout;
    logic [1:0]  a_state;
    logic [31:0] a_cycle, a_inst, a_trap;
    logic        b_cpu_rst_n, b_done, b_pass, b_timeout;
    logic [1:0]  b_state;
    logic [3:0]  b_cycle, b_inst;
    logic [31:0] b_trap;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tb_sys_ctrl #(
        .DATA_WIDTH(32), .CNT_WIDTH(32), .RST_CYCLES(4), .MAX_CYCLES(50), .PASS_CODE(0)
    ) dut_a (
        .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_inst_commit(commit), .i_ebreak(ebreak),
        .i_trap_code(code), .o_cpu_rst_n(a_cpu_rst_n), .o_state(a_state),
        .o_cycle_cnt(a_cycle), .o_inst_cnt(a_inst), .o_done(a_done), .o_pass(a_pass),
        .o_timeout(a_timeout), .o_trap_code(a_trap)
    );

    tb_sys_ctrl #(
        .DATA_WIDTH(32), .CNT_WIDTH(4), .RST_CYCLES(4), .MAX_CYCLES(0), .PASS_CODE(0)
    ) dut_b (
        .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_inst_commit(commit), .i_ebreak(ebreak),
        .i_trap_code(code), .o_cpu_rst_n(b_cpu_rst_n), .o_state(b_state),
        .o_cycle_cnt(b_cycle), .o_inst_cnt(b_inst), .o_done(b_done), .o_pass(b_pass),
        .o_timeout(b_timeout), .o_trap_code(b_trap)
    );

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset is already sampled low. Release it and check the 4-edge CPU reset hold.
    // ebreak and commit are toggled randomly during the hold; the DUT must ignore them.
    task automatic release_run();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (a_cpu_rst_n !== 1'b0 || a_state !== 2'd0) begin
                failures++;
                $display("FAIL rst_hold edge=%0d cpu_rst_n=%0b state=%0d exp 0/0",
                         k, a_cpu_rst_n, a_state);
            end
            commit = 1'($urandom_range(0, 1));
            ebreak = 1'($urandom_range(0, 1));
            step();
        end
        commit = 1'b0;
        ebreak = 1'b0;
        checks++;
        if (a_cpu_rst_n !== 1'b1 || a_state !== 2'd1 || a_cycle !== 32'd0 ||
            a_inst !== 32'd0 || a_done !== 1'b0) begin
            failures++;
            $display("FAIL run_entry cpu_rst_n=%0b state=%0d cyc=%0d inst=%0d done=%0b exp 1/1/0/0/0",
                     a_cpu_rst_n, a_state, a_cycle, a_inst, a_done);
        end
    endtask

    task automatic go_run();
        rst_n  = 1'b0;
        commit = 1'b0;
        ebreak = 1'b0;
        code   = '0;
        step();
        step();
        release_run();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (a_cpu_rst_n !== 1'b0 || a_state !== 2'd0 || a_cycle !== 32'd0 ||
            a_inst !== 32'd0 || a_done !== 1'b0 || a_pass !== 1'b0 ||
            a_timeout !== 1'b0 || a_trap !== 32'd0) begin
            failures++;
            $display("FAIL reset_a cpu=%0b st=%0d cyc=%0d inst=%0d d=%0b p=%0b t=%0b trap=%0h exp all 0",
                     a_cpu_rst_n, a_state, a_cycle, a_inst, a_done, a_pass, a_timeout, a_trap);
        end
        checks++;
        if (b_cpu_rst_n !== 1'b0 || b_state !== 2'd0 || b_cycle !== 4'd0 || b_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_b cpu=%0b st=%0d cyc=%0d d=%0b exp all 0",
                     b_cpu_rst_n, b_state, b_cycle, b_done);
        end
        release_run();
    endtask

    task automatic test_pass_halt();
        go_run();
        commit = 1'b1;
        for (int i = 0; i < 20; i++) step();
        ebreak = 1'b1;
        code   = 32'd0;
        step();
        ebreak = 1'b0;
        commit = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_pass !== 1'b1 || a_timeout !== 1'b0) begin
            failures++;
            $display("FAIL pass_flags d=%0b p=%0b t=%0b exp 1/1/0", a_done, a_pass, a_timeout);
        end
        checks++;
        if (a_cycle !== 32'd21 || a_inst !== 32'd21) begin
            failures++;
            $display("FAIL pass_counts cyc=%0d inst=%0d exp 21/21", a_cycle, a_inst);
        end
        checks++;
        if (a_cpu_rst_n !== 1'b0 || a_state !== 2'd2) begin
            failures++;
            $display("FAIL pass_state cpu=%0b st=%0d exp 0/2", a_cpu_rst_n, a_state);
        end
    endtask

    task automatic test_fail_halt();
        go_run();
        for (int i = 0; i < 5; i++) begin
            commit = 1'($urandom_range(0, 1));
            step();
        end
        ebreak = 1'b1;
        code   = 32'h0000_0001;
        step();
        checks++;
        if (a_done !== 1'b1 || a_pass !== 1'b0 || a_trap !== 32'd1 || a_timeout !== 1'b0 ||
            a_cycle !== 32'd6) begin
            failures++;
            $display("FAIL fail_halt d=%0b p=%0b trap=%0h t=%0b cyc=%0d exp 1/0/1/0/6",
                     a_done, a_pass, a_trap, a_timeout, a_cycle);
        end
        // A later ebreak with the pass code must not be latched in DONE.
        code = 32'd0;
        for (int i = 0; i < 10; i++) step();
        ebreak = 1'b0;
        commit = 1'b0;
        checks++;
        if (a_pass !== 1'b0 || a_trap !== 32'd1 || a_cycle !== 32'd6 || a_state !== 2'd2) begin
            failures++;
            $display("FAIL fail_hold p=%0b trap=%0h cyc=%0d st=%0d exp 0/1/6/2",
                     a_pass, a_trap, a_cycle, a_state);
        end
    endtask

    task automatic test_timeout();
        go_run();
        commit = 1'b1;
        for (int i = 0; i < 49; i++) step();
        checks++;
        if (a_done !== 1'b0 || a_cycle !== 32'd49) begin
            failures++;
            $display("FAIL timeout_early d=%0b cyc=%0d exp 0/49", a_done, a_cycle);
        end
        step();
        commit = 1'b0;
        checks++;
        if (a_timeout !== 1'b1 || a_done !== 1'b1 || a_pass !== 1'b0 || a_cycle !== 32'd50 ||
            a_inst !== 32'd50 || a_state !== 2'd2 || a_cpu_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL timeout t=%0b d=%0b p=%0b cyc=%0d inst=%0d st=%0d cpu=%0b exp 1/1/0/50/50/2/0",
                     a_timeout, a_done, a_pass, a_cycle, a_inst, a_state, a_cpu_rst_n);
        end
        for (int i = 0; i < 100; i++) begin
            commit = 1'($urandom_range(0, 1));
            ebreak = 1'($urandom_range(0, 1));
            code   = 32'd0;
            step();
            checks++;
            if (a_timeout !== 1'b1 || a_done !== 1'b1 || a_pass !== 1'b0 ||
                a_cycle !== 32'd50 || a_inst !== 32'd50 || a_trap !== 32'd0) begin
                failures++;
                $display("FAIL timeout_hold i=%0d t=%0b d=%0b p=%0b cyc=%0d inst=%0d trap=%0h",
                         i, a_timeout, a_done, a_pass, a_cycle, a_inst, a_trap);
            end
        end
        commit = 1'b0;
        ebreak = 1'b0;
    endtask

    task automatic test_collision();
        go_run();
        for (int i = 0; i < 49; i++) step();
        ebreak = 1'b1;
        code   = 32'd0;
        step();
        ebreak = 1'b0;
        checks++;
        if (a_pass !== 1'b1 || a_timeout !== 1'b0 || a_done !== 1'b1 || a_cycle !== 32'd50) begin
            failures++;
            $display("FAIL collision p=%0b t=%0b d=%0b cyc=%0d exp 1/0/1/50",
                     a_pass, a_timeout, a_done, a_cycle);
        end
    endtask

    task automatic test_mid_reset();
        go_run();
        commit = 1'b1;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        step();
        commit = 1'b0;
        checks++;
        if (a_cpu_rst_n !== 1'b0 || a_state !== 2'd0 || a_cycle !== 32'd0 ||
            a_inst !== 32'd0 || a_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset cpu=%0b st=%0d cyc=%0d inst=%0d d=%0b exp all 0",
                     a_cpu_rst_n, a_state, a_cycle, a_inst, a_done);
        end
        release_run();
    endtask

    task automatic test_saturation();
        int exp_cnt;
        go_run();
        commit = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            exp_cnt = (i + 1 > 15) ? 15 : i + 1;
            checks++;
            if (b_cycle !== 4'(exp_cnt) || b_inst !== 4'(exp_cnt) || b_done !== 1'b0) begin
                failures++;
                $display("FAIL saturation i=%0d cyc=%0d inst=%0d d=%0b exp %0d/%0d/0",
                         i, b_cycle, b_inst, b_done, exp_cnt, exp_cnt);
            end
        end
        commit = 1'b0;
    endtask

    // The model predicts the finish cycle and the flags from the halt index and the commit pattern.
    task automatic test_random();
        logic cm [0:69];
        int   h, end_cyc, exp_inst;
        logic halted, exp_pass;
        logic [31:0] rcode, exp_trap;
        for (int t = 0; t < 10; t++) begin
            h     = $urandom_range(0, 69);
            rcode = ($urandom_range(0, 1) == 1) ? 32'd0 : 32'($urandom_range(1, 65535));
            for (int i = 0; i < 70; i++) cm[i] = 1'($urandom_range(0, 1));
            halted   = (h < 50);
            end_cyc  = halted ? h + 1 : 50;
            exp_inst = 0;
            for (int i = 0; i < end_cyc; i++) exp_inst += int'(cm[i]);
            exp_pass = halted && (rcode == 32'd0);
            exp_trap = halted ? rcode : 32'd0;

            go_run();
            for (int i = 0; i < end_cyc + 5; i++) begin
                commit = cm[i];
                ebreak = (i == h) ? 1'b1 : 1'($urandom_range(0, 1) & (i >= end_cyc ? 1 : 0));
                code   = (i == h) ? rcode : 32'($urandom);
                step();
            end
            commit = 1'b0;
            ebreak = 1'b0;
            checks++;
            if (a_done !== 1'b1 || a_pass !== exp_pass || a_timeout !== !halted ||
                a_trap !== exp_trap || a_cycle !== 32'(end_cyc) || a_inst !== 32'(exp_inst)) begin
                failures++;
                $display("FAIL random t=%0d h=%0d d=%0b p=%0b/%0b to=%0b/%0b trap=%0h/%0h cyc=%0d/%0d inst=%0d/%0d",
                         t, h, a_done, a_pass, exp_pass, a_timeout, !halted, a_trap, exp_trap,
                         a_cycle, end_cyc, a_inst, exp_inst);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass_halt();
        test_fail_halt();
        test_timeout();
        test_collision();
        test_mid_reset();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tb_sys_ctrl.md
# tb_sys_ctrl

Parametrised run controller for CPU simulation benches. It sequences CPU reset for a programmable number of cycles and counts cycles and retired instructions. It ends a run on an `ebreak` halt or a cycle-limit timeout, and reports pass/fail from the trap code. It sits between the bench clock/reset and the `cpu` instance, replacing fixed-delay reset and hard-coded run length in the L1 and later benches.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of the trap-code input and latch
- `CNT_WIDTH`, 32, width of the cycle and instruction counters
- `RST_CYCLES`, 10, cycles the CPU is held in reset after system reset releases; legal range ≥1
- `MAX_CYCLES`, 1000, run-cycle limit before timeout; 0 disables timeout
- `PASS_CODE`, 0, trap code value that signals a pass

Ports:
- `i_sys_clk`  in  1  system clock; all logic on its rising edge
- `i_sys_rst_n`  in  1  system reset, synchronous, active-low
- `i_inst_commit`  in  1  CPU retired one instruction this cycle
- `i_ebreak`  in  1  CPU executed `ebreak` this cycle (halt request)
- `i_trap_code`  in  DATA_WIDTH  CPU `a0` value, valid when `i_ebreak`=1
- `o_cpu_rst_n`  out  1  reset to the CPU, active-low, registered
- `o_state`  out  2  current state: 0 RST, 1 RUN, 2 DONE
- `o_cycle_cnt`  out  CNT_WIDTH  cycles spent in RUN
- `o_inst_cnt`  out  CNT_WIDTH  instructions committed in RUN
- `o_done`  out  1  run finished (sticky)
- `o_pass`  out  1  finished by `ebreak` with `i_trap_code`==PASS_CODE
- `o_timeout`  out  1  finished by cycle limit
- `o_trap_code`  out  DATA_WIDTH  trap code latched at halt

## Operation
- Reset (`i_sys_rst_n`=0 at a rising edge): state RST and all counters 0. Outputs: `o_cpu_rst_n`=0, `o_state`=0, `o_done`/`o_pass`/`o_timeout`=0, `o_trap_code`=0.
- RST: an internal reset counter increments each cycle. When it equals RST_CYCLES-1, the next state is RUN and `o_cpu_rst_n` goes to 1 on the same edge.
- RUN behaviour:
  - `o_cycle_cnt` increments every RUN cycle.
  - `o_inst_cnt` increments on every cycle with `i_inst_commit`=1, including the halting cycle.
  - Both counters saturate at all-ones; there is no wrap-around.
- RUN exit on `i_ebreak`=1: the next state is DONE. On that edge:
  - `o_trap_code` ← `i_trap_code`
  - `o_pass` ← (`i_trap_code`==PASS_CODE)
  - `o_done` ← 1
- RUN exit on timeout: with MAX_CYCLES≠0, when `o_cycle_cnt`==MAX_CYCLES-1 and `i_ebreak`=0, the next state is DONE. On that edge `o_timeout` ← 1, `o_done` ← 1, and `o_pass` stays 0.
- Simultaneous `i_ebreak` and timeout condition: `ebreak` wins, so `o_timeout`=0.
- DONE:
  - `o_cpu_rst_n` drops to 0 to freeze the CPU.
  - Counters, flags and `o_trap_code` hold.
  - `i_ebreak` and `i_inst_commit` are ignored.
  - The block leaves DONE only via `i_sys_rst_n`=0.
- `i_ebreak`/`i_inst_commit` are ignored in RST.
- Reset asserted in any state returns the block to the reset values on the next edge; this includes mid-RUN.

## Timing
- Edge 0 is the first rising edge with `i_sys_rst_n`=1. `o_cpu_rst_n` reads 1 after edge RST_CYCLES-1, so the CPU sees exactly RST_CYCLES cycles of reset after release.
- The first RUN cycle has `o_cycle_cnt`=0. The edge ending it makes the count 1.
- Halt latency: `o_done` reads 1 one cycle after the cycle where `i_ebreak`=1. `o_cpu_rst_n` falls on the same edge.
- Timeout: `o_done` reads 1 after exactly MAX_CYCLES RUN cycles, with `o_cycle_cnt`=MAX_CYCLES.
- On ebreak, `o_cycle_cnt` includes the halting cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset sequence, RST_CYCLES=4: release `i_sys_rst_n` → `o_cpu_rst_n`=0 for 4 edges, then 1. `o_state` goes 0→1; counters are 0 at the first RUN cycle.
- Pass halt: `i_inst_commit`=1 every RUN cycle, `i_ebreak`=1 with `i_trap_code`=0 on RUN cycle 20 → next cycle:
  - `o_done`=1, `o_pass`=1, `o_timeout`=0
  - `o_cycle_cnt`=21, `o_inst_cnt`=21
  - `o_cpu_rst_n`=0, `o_state`=2
- Fail halt: `i_ebreak`=1 with `i_trap_code`=32'h0000_0001 → `o_done`=1, `o_pass`=0, `o_trap_code`=1.
- Timeout, MAX_CYCLES=50, no `ebreak` → after 50 RUN cycles: `o_timeout`=1, `o_done`=1, `o_pass`=0, `o_cycle_cnt`=50. Values hold for 100 further cycles.
- Collision, MAX_CYCLES=50: `i_ebreak`=1, code 0, on RUN cycle index 49 → `o_pass`=1, `o_timeout`=0.
- Mid-run reset: assert `i_sys_rst_n`=0 for 1 cycle at RUN cycle 10 → all outputs return to reset values; the sequence restarts with the full RST_CYCLES hold. Also, CNT_WIDTH=4 with MAX_CYCLES=0 → `o_cycle_cnt` saturates at 4'hF.
